// File: rtl/router_pkg.sv
// Shared constants for the router: controller state encoding and port address values.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   state_t      - 3-bit encoding of the eight router controller states
//   ADDR_INVALID - header address value that selects no output port
//   sel_port()   - picks the per-port flag addressed by a 2-bit port number
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'b000,
    LOAD_FIRST_DATA    = 3'b001,
    LOAD_DATA          = 3'b010,
    FIFO_FULL_STATE    = 3'b011,
    LOAD_AFTER_FULL    = 3'b100,
    LOAD_PARITY        = 3'b101,
    CHECK_PARITY_ERROR = 3'b110,
    WAIT_TILL_EMPTY    = 3'b111
  } state_t;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Select flags[idx] for idx 0..2; the invalid address selects nothing.
  function automatic logic sel_port(input logic [2:0] flags, input logic [1:0] idx);
    logic res;
    case (idx)
      2'd0:    res = flags[0];
      2'd1:    res = flags[1];
      2'd2:    res = flags[2];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Router controller FSM: decodes the header address, sequences payload/parity loading into one of three FIFOs.
// Latency: one clock from input to state change; all outputs are decodes of the registered state.
// Backpressure: a full target FIFO parks the FSM in FIFO_FULL_STATE; a non-empty target parks it in WAIT_TILL_EMPTY.
//
// Ports:
//   clock, reset                   - rising-edge clock, synchronous active-high reset
//   pkt_valid, data_in[1:0]        - packet strobe and header address bits from the source
//   fifo_empty_0/1/2, soft_reset_* - per-port FIFO empty flags and timeout flushes
//   fifo_full, low_pkt_valid, parity_done - status of the selected FIFO and register block
//   detect_add .. busy             - state decodes driving the register block, sync block and source
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       low_pkt_valid,
  input  logic       parity_done,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;

  assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          // The address is captured even when invalid; it is only consulted outside this state.
          addr_d = data_in;
          if (data_in != ADDR_INVALID) begin
            // Decode uses the live header bits, not the captured address, so the
            // FIFO check happens in the same cycle the header is presented.
            if (sel_port(fifo_empty, data_in)) state_d = LOAD_FIRST_DATA;
            else                               state_d = WAIT_TILL_EMPTY;
          end
        end
      end

      LOAD_FIRST_DATA: state_d = LOAD_DATA;

      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end

      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end

      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end

      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;

      CHECK_PARITY_ERROR: begin
        // The parity byte itself may have filled the FIFO.
        if (fifo_full) state_d = FIFO_FULL_STATE;
        else           state_d = DECODE_ADDRESS;
      end

      WAIT_TILL_EMPTY: begin
        if (sel_port(fifo_empty, addr_q)) state_d = LOAD_FIRST_DATA;
      end

      default: state_d = DECODE_ADDRESS;
    endcase

    // A timeout flush on the port being written abandons the packet from any
    // active state; flushes on other ports do not concern this packet.
    if ((state_q != DECODE_ADDRESS) && sel_port(soft_reset, addr_q)) begin
      state_d = DECODE_ADDRESS;
    end
  end

  // Output decode
  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state_q == LOAD_DATA) ||
                         (state_q == LOAD_AFTER_FULL) ||
                         (state_q == LOAD_PARITY);
  assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule
